// File: rtl/hoene_led_frame_rx_if.sv
// hoene_led_frame_rx_if: decoded bit stream in, forwarded stream and
// captured payload out. master = upstream/monitor side, slave = receiver.
interface hoene_led_frame_rx_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10
);
  localparam int PAYLOAD = CHANNELS * WIDTH;

  logic               in_clk;
  logic               in_data;
  logic               in_error;
  logic               in_sync;
  logic               fwd_clk;
  logic               fwd_data;
  logic [PAYLOAD-1:0] data_out;
  logic               data_valid;
  logic               parity_error;
  logic               busy;

  modport master (
    output in_clk, in_data, in_error, in_sync,
    input  fwd_clk, fwd_data, data_out,
    input  data_valid, parity_error, busy
  );

  modport slave (
    input  in_clk, in_data, in_error, in_sync,
    output fwd_clk, fwd_data, data_out,
    output data_valid, parity_error, busy
  );
endinterface

// File: rtl/hoene_led_frame_rx.sv
// hoene_led_frame_rx: captures the first frame after sync, forwards the rest.
// Define HOENE_LED_FRAME_RX_PARITY_EN to add and check an even-parity bit.
module hoene_led_frame_rx #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  hoene_led_frame_rx_if.slave bus
);
  localparam int PAYLOAD = CHANNELS * WIDTH;
`ifdef HOENE_LED_FRAME_RX_PARITY_EN
  localparam int FRAME = PAYLOAD + 2;
`else
  localparam int FRAME = PAYLOAD + 1;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] PLD  = CW'(PAYLOAD);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    FORWARD,
    ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PAYLOAD-1:0] shadow_q, shadow_d;
  logic               par_q, par_d;
  logic [PAYLOAD-1:0] data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               perr_q, perr_d;
  logic               fwd_clk_q, fwd_clk_d;
  logic               fwd_data_q, fwd_data_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    perr_d       = perr_q;
    fwd_clk_d    = 1'b0;
    fwd_data_d   = fwd_data_q;
    // Sync loss wins over everything, including a bit in the same cycle.
    if (!bus.in_sync) begin
      state_d  = IDLE;
      cnt_d    = '0;
      shadow_d = '0;
      par_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = OWN;
          cnt_d   = '0;
        end
        OWN: begin
          if (bus.in_error) begin
            state_d = ERROR;
          end else if (bus.in_clk) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '0) begin
              if (!bus.in_data) state_d = ERROR;
            end else if (cnt_q <= PLD) begin
              shadow_d = (shadow_q << 1) | PAYLOAD'(bus.in_data);
              par_d    = par_q ^ bus.in_data;
            end
            if (cnt_q == LAST) begin
              state_d = FORWARD;
`ifdef HOENE_LED_FRAME_RX_PARITY_EN
              if (par_q ^ bus.in_data) begin
                perr_d = 1'b1;
              end else begin
                data_out_d   = shadow_q;
                data_valid_d = 1'b1;
                perr_d       = 1'b0;
              end
`else
              data_out_d   = shadow_d;
              data_valid_d = 1'b1;
`endif
            end
          end
        end
        FORWARD: begin
          if (bus.in_error) begin
            state_d = ERROR;
          end else if (bus.in_clk) begin
            fwd_clk_d  = 1'b1;
            fwd_data_d = bus.in_data;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      fwd_clk_q    <= 1'b0;
      fwd_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      perr_q       <= perr_d;
      fwd_clk_q    <= fwd_clk_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

  assign bus.fwd_clk      = fwd_clk_q;
  assign bus.fwd_data     = fwd_data_q;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.parity_error = perr_q;
  assign bus.busy         = (state_q == OWN) || (state_q == FORWARD);
endmodule

// File: tb/tb_hoene_led_frame_rx.sv
// tb_hoene_led_frame_rx: directed scenarios for hoene_led_frame_rx.
// Frame length follows HOENE_LED_FRAME_RX_PARITY_EN like the design.
module tb_hoene_led_frame_rx;
`ifdef HOENE_LED_FRAME_RX_PARITY_EN
  localparam int FRAME = 32;
`else
  localparam int FRAME = 31;
`endif
  localparam logic [29:0] P1 = {10'h3FF, 10'h2AA, 10'h155};
  localparam logic [29:0] P2 = {10'h0AB, 10'h3C5, 10'h012};
  localparam logic [29:0] P3 = {10'h155, 10'h000, 10'h3FF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hoene_led_frame_rx_if #(.CHANNELS(3), .WIDTH(10)) bus ();
  hoene_led_frame_rx #(.CHANNELS(3), .WIDTH(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_fwd;
  int n_valid;
  int valid_idx;
  logic [63:0] fwd_shift;

  function automatic logic [63:0] own_vec(input logic [29:0] p,
                                          input bit badpar);
`ifdef HOENE_LED_FRAME_RX_PARITY_EN
    return 64'({1'b1, p, (^p) ^ badpar});
`else
    return 64'({1'b1, p});
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_fwd = 0;
    n_valid = 0;
    valid_idx = -1;
    fwd_shift = '0;
  endtask

  task automatic resync();
    bus.in_sync = 1'b0;
    cyc(2);
    bus.in_sync = 1'b1;
    cyc(2);
  endtask

  task automatic send_vec(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.in_clk = 1'b1;
      bus.in_data = v[i];
      @(posedge clk);
      #1;
      bus.in_clk = 1'b0;
      if (bus.fwd_clk) begin
        n_fwd++;
        fwd_shift = {fwd_shift[62:0], bus.fwd_data};
      end
      if (bus.data_valid) begin
        n_valid++;
        valid_idx = n - 1 - i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_tests++;
    if ({bus.fwd_clk, bus.fwd_data, bus.data_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes got %b exp 000",
               {bus.fwd_clk, bus.fwd_data, bus.data_valid});
    end
    n_tests++;
    if (bus.data_out !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0", bus.data_out);
    end
    n_tests++;
    if ({bus.parity_error, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 00",
               {bus.parity_error, bus.busy});
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_own_capture();
    resync();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL own_busy got %b exp 1", bus.busy);
    end
    clr();
    send_vec(own_vec(P1, 1'b0), FRAME);
    n_tests++;
    if (n_valid !== 1 || valid_idx !== FRAME - 1) begin
      n_fail++;
      $display("FAIL own_valid got %0d@%0d exp 1@%0d",
               n_valid, valid_idx, FRAME - 1);
    end
    n_tests++;
    if (bus.data_out !== P1) begin
      n_fail++;
      $display("FAIL own_data got %h exp %h", bus.data_out, P1);
    end
    n_tests++;
    if (n_fwd !== 0) begin
      n_fail++;
      $display("FAIL own_fwd got %0d exp 0", n_fwd);
    end
    cyc(1);
    n_tests++;
    if (bus.data_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL own_after got v=%b b=%b exp v=0 b=1",
               bus.data_valid, bus.busy);
    end
  endtask

  task automatic test_forward();
    clr();
    send_vec(64'(32'hDEADBEEF), 32);
    n_tests++;
    if (n_fwd !== 32) begin
      n_fail++;
      $display("FAIL fwd_count got %0d exp 32", n_fwd);
    end
    n_tests++;
    if (fwd_shift[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fwd_data got %h exp deadbeef", fwd_shift[31:0]);
    end
    n_tests++;
    if (bus.data_out !== P1 || n_valid !== 0) begin
      n_fail++;
      $display("FAIL fwd_hold got %h/%0d exp %h/0",
               bus.data_out, n_valid, P1);
    end
    cyc(1);
    n_tests++;
    if (bus.fwd_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_width got %b exp 0", bus.fwd_clk);
    end
  endtask

  task automatic test_parity();
`ifdef HOENE_LED_FRAME_RX_PARITY_EN
    resync();
    clr();
    send_vec(own_vec(P2, 1'b1), FRAME);
    n_tests++;
    if (bus.parity_error !== 1'b1 || n_valid !== 0) begin
      n_fail++;
      $display("FAIL par_bad got pe=%b v=%0d exp pe=1 v=0",
               bus.parity_error, n_valid);
    end
    n_tests++;
    if (bus.data_out !== P1) begin
      n_fail++;
      $display("FAIL par_hold got %h exp %h", bus.data_out, P1);
    end
`endif
    resync();
    clr();
    send_vec(own_vec(P2, 1'b0), FRAME);
    n_tests++;
    if (bus.parity_error !== 1'b0 || n_valid !== 1) begin
      n_fail++;
      $display("FAIL par_good got pe=%b v=%0d exp pe=0 v=1",
               bus.parity_error, n_valid);
    end
    n_tests++;
    if (bus.data_out !== P2) begin
      n_fail++;
      $display("FAIL par_data got %h exp %h", bus.data_out, P2);
    end
  endtask

  task automatic test_bad_start();
    logic [63:0] v;
    v = own_vec(P1, 1'b0);
    v[FRAME-1] = 1'b0;
    resync();
    clr();
    send_vec(v, FRAME);
    n_tests++;
    if (n_valid !== 0 || n_fwd !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_err got v=%0d f=%0d b=%b exp 0/0/0",
               n_valid, n_fwd, bus.busy);
    end
    n_tests++;
    if (bus.data_out !== P2) begin
      n_fail++;
      $display("FAIL start_hold got %h exp %h", bus.data_out, P2);
    end
    resync();
    clr();
    send_vec(own_vec(P3, 1'b0), FRAME);
    n_tests++;
    if (bus.data_out !== P3 || n_valid !== 1) begin
      n_fail++;
      $display("FAIL start_recover got %h/%0d exp %h/1",
               bus.data_out, n_valid, P3);
    end
  endtask

  task automatic test_abort();
    resync();
    clr();
    send_vec(own_vec(P1, 1'b0) >> (FRAME - 16), 16);
    bus.in_sync = 1'b0;
    cyc(2);
    bus.in_sync = 1'b1;
    cyc(2);
    send_vec(own_vec(P2, 1'b0), FRAME);
    n_tests++;
    if (bus.data_out !== P2 || n_valid !== 1) begin
      n_fail++;
      $display("FAIL abort_data got %h/%0d exp %h/1",
               bus.data_out, n_valid, P2);
    end
    bus.in_clk = 1'b1;
    bus.in_data = 1'b1;
    bus.in_sync = 1'b0;
    cyc(1);
    bus.in_clk = 1'b0;
    n_tests++;
    if (bus.fwd_clk !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_syncbit got f=%b b=%b exp 0/0",
               bus.fwd_clk, bus.busy);
    end
  endtask

  task automatic test_error();
    resync();
    clr();
    send_vec(own_vec(P1, 1'b0), FRAME);
    bus.in_clk = 1'b1;
    bus.in_data = 1'b1;
    bus.in_error = 1'b1;
    cyc(1);
    bus.in_clk = 1'b0;
    bus.in_error = 1'b0;
    n_tests++;
    if (bus.fwd_clk !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_bit got f=%b b=%b exp 0/0",
               bus.fwd_clk, bus.busy);
    end
    clr();
    send_vec(64'hFF, 8);
    n_tests++;
    if (n_fwd !== 0) begin
      n_fail++;
      $display("FAIL err_silent got %0d exp 0", n_fwd);
    end
  endtask

  task automatic test_reset_mid();
    resync();
    clr();
    send_vec(own_vec(P3, 1'b0), FRAME);
    clr();
    send_vec(64'(32'hDEADBEEF >> 12), 20);
    n_tests++;
    if (bus.fwd_clk !== 1'b1 || n_fwd !== 20) begin
      n_fail++;
      $display("FAIL rst_pre got f=%b n=%0d exp 1/20",
               bus.fwd_clk, n_fwd);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.fwd_clk !== 1'b0 || bus.fwd_data !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fwd got %b%b exp 00", bus.fwd_clk, bus.fwd_data);
    end
    n_tests++;
    if (bus.data_out !== 30'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got %h/%b exp 0/0", bus.data_out, bus.busy);
    end
    bus.in_sync = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    bus.in_clk = 1'b0;
    bus.in_data = 1'b0;
    bus.in_error = 1'b0;
    bus.in_sync = 1'b0;
    test_reset();
    test_own_capture();
    test_forward();
    test_parity();
    test_bad_start();
    test_abort();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
